// File: rtl/afpm_pkg.sv
// afpm_pkg: shared types and constants for the AFPM result serializer.
//   - tx_state_t : serializer FSM states (ST_FLAGS only with AFPM_TX_FLAGS_EN)
//   - FP16 field widths/positions, flag-byte bit indices
//   - CNT_W      : hold counter width, sized for the largest legal HOLD_CYCLES
// Config macro: AFPM_TX_FLAGS_EN (adds the FLAGS state).
package afpm_pkg;

    localparam int FP16_W        = 16;
    localparam int FP16_EXP_W    = 5;
    localparam int FP16_MANT_W   = 10;
    localparam int FP16_MANT_LSB = 0;
    localparam int FP16_EXP_LSB  = FP16_MANT_W;
    localparam int FP16_SIGN_BIT = FP16_EXP_LSB + FP16_EXP_W;

    // Flag byte layout; bits 7:5 are always zero.
    localparam int FLAG_ZERO = 0;
    localparam int FLAG_SUBN = 1;
    localparam int FLAG_INF  = 2;
    localparam int FLAG_NAN  = 3;
    localparam int FLAG_SIGN = 4;

    localparam int HOLD_MAX = 15;
    localparam int CNT_W    = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BYTE0 = 2'd1,
`ifdef AFPM_TX_FLAGS_EN
        ST_BYTE1 = 2'd2,
        ST_FLAGS = 2'd3
`else
        ST_BYTE1 = 2'd2
`endif
    } tx_state_t;

endpackage

// File: rtl/afpm_fp16_classify.sv
// afpm_fp16_classify: combinational FP16 classifier.
//   word  in  16  FP16 word: sign[15], exp[14:10], mant[9:0]
//   flags out 8   {3'b0, sign, nan, inf, subnormal, zero}
// Only instantiated when AFPM_TX_FLAGS_EN is defined.
module afpm_fp16_classify
    import afpm_pkg::*;
(
    input  logic [FP16_W-1:0] word,
    output logic [7:0]        flags
);

    logic [FP16_EXP_W-1:0]  exp_f;
    logic [FP16_MANT_W-1:0] mant_f;
    logic                   exp_zero;
    logic                   exp_max;
    logic                   mant_zero;

    always_comb begin
        exp_f     = word[FP16_EXP_LSB +: FP16_EXP_W];
        mant_f    = word[FP16_MANT_LSB +: FP16_MANT_W];
        exp_zero  = (exp_f == '0);
        exp_max   = &exp_f;
        mant_zero = (mant_f == '0);

        flags            = '0;
        flags[FLAG_ZERO] = exp_zero &&  mant_zero;
        flags[FLAG_SUBN] = exp_zero && !mant_zero;
        flags[FLAG_INF]  = exp_max  &&  mant_zero;
        flags[FLAG_NAN]  = exp_max  && !mant_zero;
        flags[FLAG_SIGN] = word[FP16_SIGN_BIT];
    end

endmodule

// File: rtl/afpm_result_serializer.sv
// afpm_result_serializer: accepts one FP16 result word (valid/ready) and
// replays it on the pad bus as low byte, high byte (and a flags byte when
// AFPM_TX_FLAGS_EN is defined), each byte held HOLD_CYCLES clocks.
//   clk, rst_n  clock, async active-low reset
//   ena         design select; low freezes the block
//   res_valid / res_data / res_ready   result word handshake (ready is comb)
//   tx_byte     byte on the pad bus (0x00 when idle)
//   tx_strobe   one-clock pulse on the first hold cycle of each byte
//   tx_last     high for every hold cycle of the final byte of a frame
// Config macro: AFPM_TX_FLAGS_EN.
// HOLD_CYCLES must be within 1..15.
module afpm_result_serializer
    import afpm_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              res_valid,
    input  logic [FP16_W-1:0] res_data,
    output logic              res_ready,
    output logic [7:0]        tx_byte,
    output logic              tx_strobe,
    output logic              tx_last
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef AFPM_TX_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    tx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FP16_W-1:0] hold_q, hold_d;
    logic [7:0]        byte_d;
    logic              strobe_d;
    logic              last_d;
    logic              last_hold;
    logic              final_byte;
    logic              xfer;

`ifdef AFPM_TX_FLAGS_EN
    logic [7:0] flags;

    // Classify the buffered word, not the live input: the input may already
    // carry the next frame's word by the time the flags byte goes out.
    afpm_fp16_classify u_classify (
        .word  (hold_q),
        .flags (flags)
    );

    assign final_byte = (state_q == ST_FLAGS);
`else
    assign final_byte = (state_q == ST_BYTE1);
`endif

    assign last_hold = (cnt_q == CNT_LAST);
    // Ready during the last hold cycle of the final byte lets a new frame
    // start on the very next clock with no idle gap.
    assign res_ready = ena && ((state_q == ST_IDLE) || (final_byte && last_hold));
    assign xfer      = res_valid && res_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        byte_d   = tx_byte;
        strobe_d = 1'b0;      // strobe is a pulse; also forced low while frozen
        last_d   = tx_last;

        if (ena) begin
            if (state_q != ST_IDLE)
                cnt_d = last_hold ? '0 : cnt_q + CNT_W'(1);

            case (state_q)
                ST_BYTE0: if (last_hold) begin
                    state_d  = ST_BYTE1;
                    byte_d   = hold_q[15:8];
                    strobe_d = 1'b1;
                    last_d   = !FLAGS_EN;
                end
`ifdef AFPM_TX_FLAGS_EN
                ST_BYTE1: if (last_hold) begin
                    state_d  = ST_FLAGS;
                    byte_d   = flags;
                    strobe_d = 1'b1;
                    last_d   = 1'b1;
                end
`endif
                default: ;
            endcase

            // Idle or end of frame: start the next word or fall back to idle.
            if (res_ready) begin
                cnt_d  = '0;
                last_d = 1'b0;
                if (xfer) begin
                    state_d  = ST_BYTE0;
                    hold_d   = res_data;
                    byte_d   = res_data[7:0];
                    strobe_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    byte_d  = 8'h00;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            tx_byte   <= 8'h00;
            tx_strobe <= 1'b0;
            tx_last   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            tx_byte   <= byte_d;
            tx_strobe <= strobe_d;
            tx_last   <= last_d;
        end
    end

endmodule

// File: doc/afpm_result_serializer.md
# afpm_result_serializer

Transmit side of the logarithmic FP multiplier's byte-serial pad protocol. Operands arrive as two bytes, low byte first, each held for two clocks. This block returns the 16-bit FP16 product the same way on `uo_out`. It accepts one result word via a valid/ready handshake, buffers it, and replays it as a framed byte sequence with a per-byte strobe. It sits between the multiplier datapath and the `uo_out` pad mux inside `tt_um_logarithmic_afpm`.

## Interface
Parameters:
- `HOLD_CYCLES`, default 2: clocks each byte is held on `tx_byte`. Legal range 1..15.

Ports:
- `clk`  in  1  the only clock; all state is updated on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `ena`  in  1  design-select. When low, the block freezes.
- `res_valid`  in  1  a result word is offered.
- `res_data`  in  16  FP16 result word: sign[15], exp[14:10], mant[9:0].
- `res_ready`  out  1  the block can accept a word this cycle.
- `tx_byte`  out  8  byte currently on the pad bus.
- `tx_strobe`  out  1  high for one clock, on the first hold cycle of each byte.
- `tx_last`  out  1  high for every hold cycle of the final byte of a frame.

## Operation
- States: IDLE, BYTE0, BYTE1, and FLAGS (FLAGS exists only with the flags option).
- Handshake:
  - A transfer occurs on a rising edge where `res_valid && res_ready`.
  - `res_data` is captured into a 16-bit holding register.
  - `res_ready = ena && (state==IDLE || last hold cycle of the final byte)`. This is combinational from state and the hold counter.
- IDLE -> BYTE0 on a transfer.
- BYTE0:
  - `tx_byte = hold[7:0]`.
  - The hold counter runs 0..HOLD_CYCLES-1, then the block moves to BYTE1.
- BYTE1:
  - `tx_byte = hold[15:8]`.
  - Without flags, this is the final byte.
  - On its last hold cycle the block goes to BYTE0 if a transfer occurs that cycle (back-to-back, no gap), otherwise to IDLE.
- In IDLE, `tx_byte` holds 0x00, and `tx_strobe` and `tx_last` are 0.
- `ena` low:
  - State, counter and holding register are frozen.
  - Outputs keep their values, except that `res_ready` is 0 and `tx_strobe` is forced to 0.
  - When `ena` returns, the current byte resumes with its remaining hold count. No extra strobe is issued.
- Data is passed through untouched: no rounding, no NaN canonicalisation.

## Timing
- Reset values (asserted immediately, asynchronously):
  - state IDLE, counter 0, holding register 0x0000.
  - `tx_byte` 0x00, `tx_strobe` 0, `tx_last` 0.
  - `res_ready` follows `ena`.
- Latency: for a transfer on edge N, byte 0 appears from cycle N+1 with `tx_strobe` high in N+1 only.
- Frame length is 2×HOLD_CYCLES clocks, or 3×HOLD_CYCLES with flags.
- Back-to-back transfers give a continuous stream: the next frame's byte 0 starts the cycle after the final hold cycle.
- If `res_valid` is asserted mid-frame, it is stalled by `res_ready=0`. The offered word must stay stable until accepted.
- With `HOLD_CYCLES=1`, every cycle is a strobe cycle, and `res_ready` is high during the whole final byte.
- Reset mid-frame aborts the frame. No partial-frame resumption occurs.
- All outputs are registered except `res_ready`.

## Configuration
- Macro `AFPM_TX_FLAGS_EN`.
- Defined:
  - A third byte follows BYTE1 in state FLAGS, with `tx_last` high during FLAGS only.
  - Flags byte layout: bit0 zero (exp=0, mant=0); bit1 subnormal (exp=0, mant≠0); bit2 infinity (exp=31, mant=0); bit3 NaN (exp=31, mant≠0); bit4 sign; bits7:5 zero.
  - Flags are computed from the holding register.
- Undefined:
  - The FLAGS state and the classifier do not exist.
  - The frame is two bytes, with `tx_last` high during BYTE1.

## Structure
- Package `afpm_pkg` holds:
  - the state enum;
  - FP16 field widths and positions (`FP16_EXP_W=5`, `FP16_MANT_W=10`);
  - flag bit indices;
  - the counter width, derived from the HOLD_CYCLES maximum of 15 (4 bits).
- One sub-module, `afpm_fp16_classify`: combinational, producing 16-bit word -> 8-bit flags. It is instantiated only under `AFPM_TX_FLAGS_EN`.

## Test plan
- Reset, `ena=1`, no valid -> `tx_byte=0x00`, `tx_strobe=0`, `tx_last=0`, `res_ready=1`.
- Single word, HOLD_CYCLES=2: transfer 0x4480 (1.5×3) -> the stream is as follows, with `tx_last` high during the 0x44 byte and the block back in IDLE afterwards:
  - 0x80 for 2 clocks, strobe in the first of them;
  - then 0x44 for 2 clocks, strobe in the first of them.
- Back-to-back: 0x3E00 held valid, then 0x4200 offered on the final hold cycle -> bytes 00,3E,00,42 with no idle gap, and exactly 4 strobes.
- `ena` dropped for 3 clocks in the middle of byte 0x3E -> the byte is held, with no strobe and `res_ready=0`. After `ena` returns, the byte completes its remaining 1 hold cycle.
- `rst_n` asserted during BYTE1 of 0x4480 -> outputs are 0 in the same cycle. After release, the block is in IDLE and emits nothing until the next transfer.
- With `AFPM_TX_FLAGS_EN`, transfer 0xFC00 -> bytes 00, FC, then 0x14 (inf|sign), with `tx_last` only on 0x14.
- With `AFPM_TX_FLAGS_EN`, transfer 0x7E01 -> flags byte 0x08.
